// File: rtl/mips_multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// ALU/mux select codes and the packed control word driven by the decoder.
package mips_multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mips_multi_cycle_control_decoder.sv
// Combinational state -> control-word map; any state not listed drives all zeros.
module mips_main_decoder
    import mips_multi_cycle_control_pkg::*;
(
    input  state_e i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctl
);

    always_comb begin
        o_ctl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctl.mem_read  = 1'b1;
                o_ctl.alu_src_b = SRCB_FOUR;
                o_ctl.alu_op    = ALU_ADD;
                o_ctl.pc_source = PC_ALU;
                // PC and IR latch only on the cycle the fetch completes
                o_ctl.pc_write  = i_mem_ready;
                o_ctl.ir_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctl.alu_src_b = SRCB_IMM_SH;
                o_ctl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                o_ctl.alu_src_a = 1'b1;
                o_ctl.alu_src_b = SRCB_IMM;
                o_ctl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                o_ctl.mem_read = 1'b1;
                o_ctl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctl.reg_write  = 1'b1;
                o_ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctl.mem_write = 1'b1;
                o_ctl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                o_ctl.alu_src_a = 1'b1;
                o_ctl.alu_src_b = SRCB_REG;
                o_ctl.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                o_ctl.reg_write = 1'b1;
                o_ctl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctl.alu_src_a     = 1'b1;
                o_ctl.alu_src_b     = SRCB_REG;
                o_ctl.alu_op        = ALU_SUB;
                o_ctl.pc_source     = PC_ALUOUT;
                o_ctl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                o_ctl.pc_write  = 1'b1;
                o_ctl.pc_source = PC_JUMP;
            end
            S_ADDI_WB: o_ctl.reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multi_cycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic, retired
// instruction counter and sticky illegal-opcode flag around the main decoder.
module mips_multi_cycle_control
    import mips_multi_cycle_control_pkg::*;
#(
    parameter int INSTR_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             opcode,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic [1:0]             pc_source,
    output logic [3:0]             state_o,
    output logic [INSTR_CNT_W-1:0] instr_retired,
    output logic                   illegal_op
);

    state_e                 r_state;
    state_e                 w_next;
    logic                   w_retire;
    logic                   w_illegal;
    ctrl_t                  w_ctl;
    logic [INSTR_CNT_W-1:0] r_retired;
    logic                   r_illegal;
    // Branch qualification with zero happens in the datapath, not here
    logic                   w_unused_zero;

    assign w_unused_zero = zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + 1'b1;
            if (w_illegal)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_illegal = 1'b1;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                if (mem_ready) w_retire = 1'b1;
                else           w_next   = S_MEM_WRITE;
            end
            S_EXECUTE:   w_next = S_ALU_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_retire = 1'b1;
            default: ;
        endcase
    end

    mips_main_decoder u_dec (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctl       (w_ctl)
    );

    // Strobes are gated combinationally so they drop the instant reset asserts
    assign pc_write      = w_ctl.pc_write      & rst;
    assign pc_write_cond = w_ctl.pc_write_cond & rst;
    assign mem_read      = w_ctl.mem_read      & rst;
    assign mem_write     = w_ctl.mem_write     & rst;
    assign ir_write      = w_ctl.ir_write      & rst;
    assign reg_write     = w_ctl.reg_write     & rst;
    assign i_or_d        = w_ctl.i_or_d;
    assign reg_dst       = w_ctl.reg_dst;
    assign mem_to_reg    = w_ctl.mem_to_reg;
    assign alu_src_a     = w_ctl.alu_src_a;
    assign alu_src_b     = w_ctl.alu_src_b;
    assign alu_op        = w_ctl.alu_op;
    assign pc_source     = w_ctl.pc_source;
    assign state_o       = r_state;
    assign instr_retired = r_retired;
    assign illegal_op    = r_illegal;

endmodule

// File: doc/mips_multi_cycle_control.md
MIPS_MULTI_CYCLE_CONTROL -- requirements
Module: mips_multi_cycle_control

Interface
REQ-001 Parameter: INSTR_CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 opcode  input  6  IR[31:26], valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, used in BRANCH.
REQ-006 mem_ready  input  1  memory handshake; 1 = current access completes this cycle.
REQ-007 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath strobes/selects.
REQ-008 alu_src_b, alu_op, pc_source  output  2 each  datapath mux/ALU selects.
REQ-009 state_o  output  4  current state encoding, for debug/waveforms.
REQ-010 instr_retired  output  INSTR_CNT_W  count of completed instructions.
REQ-011 illegal_op  output  1  sticky flag, unsupported opcode decoded.

Function
REQ-012 Moore FSM; states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
REQ-013 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; pc_write=ir_write=mem_ready; stay in FETCH while mem_ready=0, else -> DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 000000->EXECUTE, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EXEC, any other->FETCH with illegal_op set.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEM_READ, sw->MEM_WRITE.
REQ-016 MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then -> MEM_WB.
REQ-017 MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
REQ-018 MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then -> FETCH.
REQ-019 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB; ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1 -> FETCH (datapath qualifies with zero).
REQ-021 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-022 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB; ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-023 All outputs not listed for a state are 0.
REQ-024 instr_retired increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE(completed), ALU_WB, BRANCH, JUMP, ADDI_WB; illegal-opcode return does not count; wraps modulo 2^INSTR_CNT_W.
REQ-025 Latencies with mem_ready=1: lw 5 cycles, sw/R/addi 4, beq/j 3; each mem_ready=0 cycle in FETCH/MEM_READ/MEM_WRITE adds 1.
REQ-026 Invalid state encodings (12-15) -> FETCH on next edge, all outputs 0 while there.

Reset
REQ-027 rst=0 asynchronously forces state=FETCH, instr_retired=0, illegal_op=0.
REQ-028 While rst=0 all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced 0 regardless of state.
REQ-029 Reset mid-instruction abandons it; no count, first post-reset edge evaluates FETCH.

Structure
REQ-030 Shared package/header: state encodings, opcode constants, alu_op codes, pc_source codes.
REQ-031 One sub-module natural: mips_main_decoder (combinational state->control-word map); FSM/counter in top.

Verification
REQ-032 Reset: rst=0 then 1, opcode=x, mem_ready=1 -> state_o=0, instr_retired=0, first cycle mem_read=1, pc_write=1, ir_write=1.
REQ-033 lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in cycle 5; instr_retired=1.
REQ-034 sw (101011), mem_ready low 3 cycles in MEM_WRITE -> mem_write held 4 cycles, reg_write never 1, instr_retired=1 after 7 cycles.
REQ-035 Sequence R, addi, beq, j with mem_ready=1 -> total 14 cycles, instr_retired=4, correct pc_source 01 in BRANCH and 10 in JUMP.
REQ-036 opcode=111111 -> DECODE->FETCH, illegal_op=1 sticky, instr_retired unchanged; clears only on rst=0.
REQ-037 rst=0 asserted in MEM_READ mid-cycle -> strobes drop immediately, state_o=0 without clock edge.
